compute_pipe: RTL and testbench
===============================

Name: compute_pipe

Overview:
Pipelined, parametrised successor to the single-record compute FSM. It accepts one vertex record per cycle from the read→compute FIFO and applies the accumulate or update operator in a fixed-latency pipeline. Results go to the compute→write FIFO and the compute→link FIFO through an internal credit-managed output buffer. It adds fixed-point arithmetic, threshold-based deferral, link suppression for zero-degree vertices, and independent draining of the two output FIFOs.

Parameters:
DATA_WIDTH, 32, width W of every field
FRAC_BITS, 16, fractional bits of mult_factor in the g computation
LATENCY, 3, pipeline stages from input capture to output buffer (≥1)
BUF_DEPTH, 8, output buffer entries (power of 2, ≥2)
IN_WIDTH, 9*DATA_WIDTH+2, input record width
WR_WIDTH, 8*DATA_WIDTH+1, write record width
LINK_WIDTH, 3*DATA_WIDTH, link record width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_q  in  IN_WIDTH  {mod,filter,msg,self_links,mult,size,ptr,pri,delta,val,key}, key at LSBs
in_empty  in  1  input FIFO empty
in_rdreq  out  1  input FIFO read request; data valid the following cycle
wr_data  out  WR_WIDTH  write record {filt,self_links,mult,size,ptr,pri,delta_o,val_o,key}
wr_full  in  1  write FIFO full
wr_wrreq  out  1  write FIFO write strobe
link_data  out  LINK_WIDTH  {ptr,size,g}
link_full  in  1  link FIFO full
link_wrreq  out  1  link FIFO write strobe
algo_sel  in  1  0 = sum operator, 1 = max operator
thresh_en  in  1  enable threshold deferral
filter_threshold  in  W  deferral threshold (unsigned)
tc_key  out  W  termcheck key
tc_val  out  W  termcheck value (pre-update val)
tc_wren  out  1  termcheck strobe
busy  out  1  records in flight or buffered

Behaviour:
- Reset: all outputs 0; pipeline valid bits cleared; buffer empty; credits = BUF_DEPTH. Reset mid-operation discards in-flight and buffered records.
- Issue: in_rdreq = !in_empty && credits>0, registered. credits = BUF_DEPTH − (in-flight + buffered). Decrement on rdreq; increment on buffer pop. The buffer therefore never overflows.
- Latency: rdreq in cycle t; in_q captured in cycle t+1; record enters the buffer at the end of cycle t+1+LATENCY. Earliest wr_wrreq is in cycle t+2+LATENCY. Throughput is 1 record/cycle.
- Arithmetic is unsigned, W bits:
  - sum(a,b) saturates at 2^W−1.
  - max(a,b) is the greater value.
  - op = sum if algo_sel=0, max if algo_sel=1.
  - g = min((delta*mult)>>FRAC_BITS, 2^W−1) when algo_sel=0; g = val when algo_sel=1.
- Record classes (mod=1 is accumulate):
  - ACCUM (mod=1): write {0,…,pri,op(msg,delta),val,key}. No link, no termcheck.
  - FILTERED (mod=0, filter=1): write {1,…,pri,delta,val,key}. No link.
  - DEFERRED (mod=0, filter=0, thresh_en=1, g<filter_threshold): write {1,…,pri,delta,val,key}. No link.
  - UPDATE (all other mod=0 records): write {0,…,pri,0,op(val,delta),key}. Link {ptr,size,g} only if size≠0.
- Termcheck: every mod=0 record pulses tc_wren for exactly 1 cycle, in cycle t+2, with tc_key=key and tc_val=val.
- algo_sel and thresh_en are sampled at input capture and carried with the record, so mid-stream changes affect only later records.
- Buffer: FIFO of entries {wr record, link record, link_pending}.
  - Write part of the head drains when !wr_full.
  - Link part of the head drains when !link_full and link_pending.
  - Each part is written exactly once; the two may go in the same or different cycles.
  - The head pops once both parts are done.
  - wr_wrreq/link_wrreq and data are registered and are never asserted while the matching full was high in the deciding cycle.
- Order: write records leave in input order; link records leave in input order.
- A simultaneous buffer push and pop in one cycle is legal and keeps occupancy unchanged.
- busy = credits≠BUF_DEPTH.

Test Plan:
- Reset, then one UPDATE record: key=5, val=10, delta=6, mult=0x8000, size=3, ptr=0x100, algo_sel=0, rdreq at cycle 0 → cycle 2: tc_wren with key 5, val 10. Cycle 5 (LATENCY=3): wr_data val_o=16, delta_o=0, filt=0. link_data {0x100,3,3}.
- ACCUM record: msg=7, delta=5, algo_sel=1 → write delta_o=7, filt=0; no link_wrreq, no tc_wren. Repeat with algo_sel=0 → delta_o=12.
- Saturation: val=0xFFFFFFF0, delta=0x20, algo_sel=0 → val_o=0xFFFFFFFF. delta=0xFFFFFFFF, mult=0xFFFFFFFF → g=0xFFFFFFFF.
- Deferral and size 0: thresh_en=1, threshold=100, g=50 → filt=1, delta/val unchanged, no link. An UPDATE with size=0 → write only.
- Backpressure: stream 20 back-to-back records; hold link_full high for 15 cycles → credits reach 0; in_rdreq stays low; no record lost or duplicated; order preserved on both FIFOs. Then hold wr_full instead and check the same properties.
- Reset asserted with 5 records in flight → next cycle all strobes 0, busy=0, credits=BUF_DEPTH; a new record then processes normally.

Source files
------------

// File: rtl/compute_pipe.sv
// compute_pipe: fixed-latency vertex operator pipeline. Reads one record per
// cycle from the read->compute FIFO, applies the accumulate/update operator,
// and feeds the write and link FIFOs through a credit-managed output buffer
// whose write and link halves drain independently.
module compute_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int LATENCY    = 3,
  parameter int BUF_DEPTH  = 8,
  parameter int IN_WIDTH   = 9*DATA_WIDTH+2,
  parameter int WR_WIDTH   = 8*DATA_WIDTH+1,
  parameter int LINK_WIDTH = 3*DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   in_q,
  input  logic                  in_empty,
  output logic                  in_rdreq,
  output logic [WR_WIDTH-1:0]   wr_data,
  input  logic                  wr_full,
  output logic                  wr_wrreq,
  output logic [LINK_WIDTH-1:0] link_data,
  input  logic                  link_full,
  output logic                  link_wrreq,
  input  logic                  algo_sel,
  input  logic                  thresh_en,
  input  logic [DATA_WIDTH-1:0] filter_threshold,
  output logic [DATA_WIDTH-1:0] tc_key,
  output logic [DATA_WIDTH-1:0] tc_val,
  output logic                  tc_wren,
  output logic                  busy
);
  localparam int W     = DATA_WIDTH;
  localparam int ENT_W = WR_WIDTH + LINK_WIDTH + 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  // sum saturates at all-ones; max picks the larger operand
  function automatic logic [W-1:0] op_f(input logic sel_max, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sel_max) return (a > b) ? a : b;
    return s[W] ? '1 : s[W-1:0];
  endfunction

  // ---------------- issue / credits ----------------
  logic             in_rdreq_q, rd_vld_q, issue, pop;
  logic [CNT_W-1:0] credits_q, credits_d;

  // A read may issue only while a buffer slot is still unclaimed
  always_comb begin
    issue     = !in_empty && (credits_q != '0);
    credits_d = credits_q - CNT_W'(issue) + CNT_W'(pop);
  end

  // Read request register, data-valid delay and credit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rdreq_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      credits_q  <= DEPTH_C;
    end else begin
      in_rdreq_q <= issue;
      rd_vld_q   <= in_rdreq_q;
      credits_q  <= credits_d;
    end
  end

  // ---------------- capture stage ----------------
  logic                s1_vld_q, s1_algo_q, s1_thr_en_q;
  logic [IN_WIDTH-1:0] s1_rec_q;
  logic [W-1:0]        s1_thr_q, tc_key_q, tc_val_q;
  logic                tc_wren_q;

  // Capture the record with the controls in force at that moment; pulse termcheck for updates
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      tc_wren_q <= 1'b0;
      tc_key_q  <= '0;
      tc_val_q  <= '0;
    end else begin
      s1_vld_q  <= rd_vld_q;
      tc_wren_q <= rd_vld_q && !in_q[9*W+1];
      if (rd_vld_q) begin
        s1_rec_q    <= in_q;
        s1_algo_q   <= algo_sel;
        s1_thr_en_q <= thresh_en;
        s1_thr_q    <= filter_threshold;
        tc_key_q    <= in_q[W-1:0];
        tc_val_q    <= in_q[2*W-1:W];
      end
    end
  end

  // ---------------- operator ----------------
  logic                  f_mod, f_filter, deferred, link_pend_c;
  logic [W-1:0]          f_msg, f_sl, f_mult, f_size, f_ptr, f_pri, f_delta, f_val, f_key, g;
  logic [2*W-1:0]        prod, scaled;
  logic [WR_WIDTH-1:0]   wr_c;
  logic [LINK_WIDTH-1:0] link_c;
  logic [ENT_W-1:0]      ent_c;

  assign f_mod    = s1_rec_q[9*W+1];
  assign f_filter = s1_rec_q[9*W];
  assign f_msg    = s1_rec_q[9*W-1:8*W];
  assign f_sl     = s1_rec_q[8*W-1:7*W];
  assign f_mult   = s1_rec_q[7*W-1:6*W];
  assign f_size   = s1_rec_q[6*W-1:5*W];
  assign f_ptr    = s1_rec_q[5*W-1:4*W];
  assign f_pri    = s1_rec_q[4*W-1:3*W];
  assign f_delta  = s1_rec_q[3*W-1:2*W];
  assign f_val    = s1_rec_q[2*W-1:W];
  assign f_key    = s1_rec_q[W-1:0];

  // Classify the captured record and build its write/link results
  always_comb begin
    prod        = {{W{1'b0}}, f_delta} * {{W{1'b0}}, f_mult};
    scaled      = prod >> FRAC_BITS;
    g           = s1_algo_q ? f_val : ((|scaled[2*W-1:W]) ? '1 : scaled[W-1:0]);
    deferred    = s1_thr_en_q && (g < s1_thr_q);
    link_pend_c = 1'b0;
    link_c      = {f_ptr, f_size, g};
    wr_c        = {1'b1, f_sl, f_mult, f_size, f_ptr, f_pri, f_delta, f_val, f_key};
    if (f_mod) begin
      wr_c = {1'b0, f_sl, f_mult, f_size, f_ptr, f_pri, op_f(s1_algo_q, f_msg, f_delta),
              f_val, f_key};
    end else if (!f_filter && !deferred) begin
      wr_c = {1'b0, f_sl, f_mult, f_size, f_ptr, f_pri, {W{1'b0}},
              op_f(s1_algo_q, f_val, f_delta), f_key};
      link_pend_c = (f_size != '0);
    end
    ent_c = {link_pend_c, link_c, wr_c};
  end

  // ---------------- delay stages ----------------
  logic             push_vld;
  logic [ENT_W-1:0] push_ent;

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push_vld = s1_vld_q;
      assign push_ent = ent_c;
    end else begin : g_pipe
      logic [ENT_W-1:0]   ent_q [LATENCY-1];
      logic [LATENCY-2:0] vld_q;
      // Shift results toward the buffer so every record sees the same latency
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= s1_vld_q;
          ent_q[0] <= ent_c;
          for (int k = 1; k < LATENCY-1; k++) begin
            vld_q[k] <= vld_q[k-1];
            ent_q[k] <= ent_q[k-1];
          end
        end
      end
      assign push_vld = vld_q[LATENCY-2];
      assign push_ent = ent_q[LATENCY-2];
    end
  endgenerate

  // ---------------- output buffer ----------------
  logic [ENT_W-1:0]      buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_done_q, link_done_q, head_vld, head_lp, wr_go, link_go, store, deq;
  logic [ENT_W-1:0]      head_ent;
  logic                  wr_wrreq_q, link_wrreq_q;
  logic [WR_WIDTH-1:0]   wr_data_q;
  logic [LINK_WIDTH-1:0] link_data_q;

  // When empty, the arriving entry is presented as head so it can leave with no extra cycle
  always_comb begin
    head_vld = (count_q != '0) || push_vld;
    head_ent = (count_q != '0) ? buf_mem[rd_ptr_q] : push_ent;
    head_lp  = head_ent[ENT_W-1];
    wr_go    = head_vld && !wr_done_q && !wr_full;
    link_go  = head_vld && head_lp && !link_done_q && !link_full;
    pop      = head_vld && (wr_done_q || wr_go) && (!head_lp || link_done_q || link_go);
    store    = push_vld && !((count_q == '0) && pop);
    deq      = pop && (count_q != '0);
  end

  // Buffer storage write; occupancy tracking keeps stale entries unread
  always_ff @(posedge clk) begin
    if (store) buf_mem[wr_ptr_q] <= push_ent;
  end

  // Buffer pointers, per-part completion flags and registered FIFO strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wr_done_q    <= 1'b0;
      link_done_q  <= 1'b0;
      wr_wrreq_q   <= 1'b0;
      link_wrreq_q <= 1'b0;
      wr_data_q    <= '0;
      link_data_q  <= '0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_q + CNT_W'(store) - CNT_W'(deq);
      wr_done_q    <= pop ? 1'b0 : (wr_done_q || wr_go);
      link_done_q  <= pop ? 1'b0 : (link_done_q || link_go);
      wr_wrreq_q   <= wr_go;
      link_wrreq_q <= link_go;
      if (wr_go)   wr_data_q   <= head_ent[WR_WIDTH-1:0];
      if (link_go) link_data_q <= head_ent[WR_WIDTH +: LINK_WIDTH];
    end
  end

  assign in_rdreq   = in_rdreq_q;
  assign wr_wrreq   = wr_wrreq_q;
  assign wr_data    = wr_data_q;
  assign link_wrreq = link_wrreq_q;
  assign link_data  = link_data_q;
  assign tc_wren    = tc_wren_q;
  assign tc_key     = tc_key_q;
  assign tc_val     = tc_val_q;
  assign busy       = (credits_q != DEPTH_C);
endmodule

// File: tb/tb_compute_pipe.sv
// tb_compute_pipe: directed and randomised checks of compute_pipe against a
// bench-side reference model with scoreboard queues for all three outputs.
module tb_compute_pipe;
  localparam int W    = 32;
  localparam int L    = 3;
  localparam int D    = 8;
  localparam int IN_W = 9*W+2;
  localparam int WR_W = 8*W+1;
  localparam int LK_W = 3*W;

  typedef struct packed {
    logic        mod;
    logic        filt;
    logic [31:0] msg;
    logic [31:0] sl;
    logic [31:0] mult;
    logic [31:0] size;
    logic [31:0] ptr;
    logic [31:0] pri;
    logic [31:0] delta;
    logic [31:0] val;
    logic [31:0] key;
  } rec_t;

  logic            clk, reset;
  logic [IN_W-1:0] in_q;
  logic            in_empty, in_rdreq;
  logic [WR_W-1:0] wr_data;
  logic            wr_full, wr_wrreq;
  logic [LK_W-1:0] link_data;
  logic            link_full, link_wrreq;
  logic            algo_sel, thresh_en;
  logic [W-1:0]    filter_threshold, tc_key, tc_val;
  logic            tc_wren, busy;

  compute_pipe #(.DATA_WIDTH(W), .FRAC_BITS(16), .LATENCY(L), .BUF_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_q(in_q), .in_empty(in_empty), .in_rdreq(in_rdreq),
    .wr_data(wr_data), .wr_full(wr_full), .wr_wrreq(wr_wrreq),
    .link_data(link_data), .link_full(link_full), .link_wrreq(link_wrreq),
    .algo_sel(algo_sel), .thresh_en(thresh_en), .filter_threshold(filter_threshold),
    .tc_key(tc_key), .tc_val(tc_val), .tc_wren(tc_wren), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IN_W-1:0] in_fifo [$];
  logic [WR_W-1:0] wr_exp  [$];
  logic [LK_W-1:0] lk_exp  [$];
  logic [63:0]     tc_exp  [$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic wr_full_s = 1'b0;
  logic link_full_s = 1'b0;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opm(input logic mx, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = {32'd0, a} + {32'd0, b};
    if (mx) return (a >= b) ? a : b;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic send(input rec_t r);
    logic [63:0] p;
    logic [31:0] g;
    logic [WR_W-1:0] wr;
    p = ({32'd0, r.delta} * {32'd0, r.mult}) >> 16;
    if (algo_sel) g = r.val;
    else g = (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    if (r.mod)
      wr = {1'b0, r.sl, r.mult, r.size, r.ptr, r.pri, opm(algo_sel, r.msg, r.delta), r.val, r.key};
    else if (r.filt || (thresh_en && g < filter_threshold))
      wr = {1'b1, r.sl, r.mult, r.size, r.ptr, r.pri, r.delta, r.val, r.key};
    else begin
      wr = {1'b0, r.sl, r.mult, r.size, r.ptr, r.pri, 32'd0, opm(algo_sel, r.val, r.delta), r.key};
      if (r.size != 0) lk_exp.push_back({r.ptr, r.size, g});
    end
    wr_exp.push_back(wr);
    if (!r.mod) tc_exp.push_back({r.key, r.val});
    in_fifo.push_back(r);
  endtask

  function automatic rec_t mk(input logic md, input logic fl, input logic [31:0] key,
                              input logic [31:0] val, input logic [31:0] delta,
                              input logic [31:0] mult, input logic [31:0] size,
                              input logic [31:0] ptr, input logic [31:0] msg);
    rec_t r;
    r.mod = md; r.filt = fl; r.msg = msg; r.sl = 32'h11; r.mult = mult; r.size = size;
    r.ptr = ptr; r.pri = key ^ 32'h55; r.delta = delta; r.val = val; r.key = key;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.mod = ($urandom_range(0, 3) == 0); r.filt = ($urandom_range(0, 3) == 0);
    r.msg = $urandom; r.sl = $urandom; r.ptr = $urandom; r.pri = $urandom;
    r.key = $urandom; r.val = $urandom; r.size = $urandom_range(0, 3);
    r.mult = $urandom_range(0, 32'h20000);
    r.delta = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
    return r;
  endfunction

  // Input FIFO model: data appears the cycle after a read; empty accounts for the read in flight
  initial begin : fifo_drv
    logic rd_prev;
    rd_prev = 1'b0; in_q = '0; in_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (rd_prev && in_fifo.size() > 0) in_q = in_fifo.pop_front();
      rd_prev  = in_rdreq && !reset;
      in_empty = (in_fifo.size() <= (in_rdreq ? 1 : 0));
    end
  end

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    wr_full_s   <= wr_full;
    link_full_s <= link_full;
  end

  // Scoreboard: compare every strobe against the head of its expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_full_s)   chk("wr_while_full", wr_wrreq, 1'b0);
      if (link_full_s) chk("link_while_full", link_wrreq, 1'b0);
      if (wr_wrreq) begin
        if (wr_exp.size() == 0) chk("wr_unexpected", wr_wrreq, 1'b0);
        else chk("wr_data", wr_data, wr_exp.pop_front());
      end
      if (link_wrreq) begin
        if (lk_exp.size() == 0) chk("link_unexpected", link_wrreq, 1'b0);
        else chk("link_data", link_data, lk_exp.pop_front());
      end
      if (tc_wren) begin
        if (tc_exp.size() == 0) chk("tc_unexpected", tc_wren, 1'b0);
        else chk("tc_data", {tc_key, tc_val}, tc_exp.pop_front());
      end
    end
  end

  task automatic wait_idle(input string tag, input bit rnd);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (rnd) begin
        wr_full   = ($urandom_range(0, 2) == 0);
        link_full = ($urandom_range(0, 2) == 0);
      end else begin
        wr_full = 1'b0; link_full = 1'b0;
      end
      done = !busy && !in_rdreq && in_fifo.size() == 0 && wr_exp.size() == 0 &&
             lk_exp.size() == 0 && tc_exp.size() == 0;
    end
    wr_full = 1'b0; link_full = 1'b0;
    chk({tag, "_drain"}, done, 1'b1);
  endtask

  initial begin : main
    int t0, tt, tw, rdq, wrc, lkc;
    reset = 1'b1; wr_full = 1'b0; link_full = 1'b0;
    algo_sel = 1'b0; thresh_en = 1'b0; filter_threshold = '0;
    repeat (3) @(negedge clk);
    chk("rst_wrreq", wr_wrreq, 1'b0);
    chk("rst_linkreq", link_wrreq, 1'b0);
    chk("rst_tc", tc_wren, 1'b0);
    chk("rst_rdreq", in_rdreq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrdata", wr_data, '0);
    reset = 1'b0;

    // Single UPDATE record: latency and exact values
    send(mk(1'b0, 1'b0, 5, 10, 6, 32'h8000, 3, 32'h100, 0));
    t0 = -100; tt = -1; tw = -1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (in_rdreq) begin t0 = cyc; break; end end
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tc_wren) begin tt = cyc; break; end end
    chk("tc_latency", tt - t0, 2);
    chk("tc_key", tc_key, 5);
    chk("tc_val", tc_val, 10);
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (wr_wrreq) begin tw = cyc; break; end end
    chk("wr_latency", tw - t0, 2 + L);
    chk("t1_val_o", wr_data[63:32], 16);
    chk("t1_delta_o", wr_data[95:64], 0);
    chk("t1_filt", wr_data[256], 1'b0);
    chk("t1_link_strobe", link_wrreq, 1'b1);
    chk("t1_link", link_data, {32'h100, 32'd3, 32'd3});
    wait_idle("t1", 1'b0);

    // ACCUM under both operators
    algo_sel = 1'b1; send(mk(1'b1, 1'b0, 6, 9, 5, 32'h8000, 4, 32'h200, 7)); wait_idle("acc_max", 1'b0);
    algo_sel = 1'b0; send(mk(1'b1, 1'b0, 7, 9, 5, 32'h8000, 4, 32'h200, 7)); wait_idle("acc_sum", 1'b0);

    // Saturation of val_o and g, plus max-mode update
    send(mk(1'b0, 1'b0, 8, 32'hFFFF_FFF0, 32'h20, 0, 0, 32'h300, 0));
    send(mk(1'b0, 1'b0, 9, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h301, 0));
    wait_idle("sat", 1'b0);
    algo_sel = 1'b1; send(mk(1'b0, 1'b0, 10, 40, 25, 32'h8000, 2, 32'h302, 0));
    wait_idle("upd_max", 1'b0);
    algo_sel = 1'b0;

    // Deferral, filtered, zero-degree
    thresh_en = 1'b1; filter_threshold = 100;
    send(mk(1'b0, 1'b0, 11, 77, 100, 32'h8000, 5, 32'h400, 0));
    send(mk(1'b0, 1'b0, 12, 77, 400, 32'h8000, 5, 32'h401, 0));
    send(mk(1'b0, 1'b1, 13, 77, 400, 32'h8000, 5, 32'h402, 0));
    wait_idle("defer", 1'b0);
    thresh_en = 1'b0;
    send(mk(1'b0, 1'b0, 14, 20, 30, 32'h8000, 0, 32'h403, 0));
    wait_idle("size0", 1'b0);

    // Backpressure on the link FIFO
    link_full = 1'b1;
    for (int i = 0; i < 20; i++) send(mk(1'b0, 1'b0, 100 + i, i, 2 * i, 32'h10000, 1 + i, 32'h500 + i, 0));
    rdq = 0; wrc = 0; lkc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); rdq += int'(in_rdreq); wrc += int'(wr_wrreq); lkc += int'(link_wrreq);
    end
    chk("bpl_rdreqs", rdq, D);
    chk("bpl_wr", wrc, 1);
    chk("bpl_link", lkc, 0);
    chk("bpl_rdreq_low", in_rdreq, 1'b0);
    chk("bpl_credits", dut.credits_q, 0);
    link_full = 1'b0;
    wait_idle("bpl", 1'b0);

    // Backpressure on the write FIFO
    wr_full = 1'b1;
    for (int i = 0; i < 20; i++) send(mk(1'b0, 1'b0, 200 + i, 3 * i, i, 32'h18000, 1 + i, 32'h600 + i, 0));
    rdq = 0; wrc = 0; lkc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); rdq += int'(in_rdreq); wrc += int'(wr_wrreq); lkc += int'(link_wrreq);
      wr_full = 1'b1;
    end
    chk("bpw_rdreqs", rdq, D);
    chk("bpw_wr", wrc, 0);
    chk("bpw_link", lkc, 1);
    chk("bpw_rdreq_low", in_rdreq, 1'b0);
    chk("bpw_credits", dut.credits_q, 0);
    wr_full = 1'b0;
    wait_idle("bpw", 1'b0);

    // Random mixed streams with random backpressure on both outputs
    thresh_en = 1'b1; filter_threshold = 200;
    for (int i = 0; i < 40; i++) send(rand_rec());
    wait_idle("rnd_sum", 1'b1);
    algo_sel = 1'b1; thresh_en = 1'b0;
    for (int i = 0; i < 40; i++) send(rand_rec());
    wait_idle("rnd_max", 1'b1);
    algo_sel = 1'b0;

    // Reset with records in flight
    for (int i = 0; i < 5; i++) send(mk(1'b0, 1'b0, 300 + i, i, i, 32'h10000, 2, 32'h700, 0));
    repeat (4) @(negedge clk);
    reset = 1'b1;
    in_fifo.delete(); wr_exp.delete(); lk_exp.delete(); tc_exp.delete();
    @(negedge clk);
    chk("mrst_wrreq", wr_wrreq, 1'b0);
    chk("mrst_linkreq", link_wrreq, 1'b0);
    chk("mrst_tc", tc_wren, 1'b0);
    chk("mrst_rdreq", in_rdreq, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_credits", dut.credits_q, D);
    reset = 1'b0;
    @(negedge clk);
    send(mk(1'b0, 1'b0, 400, 50, 8, 32'h8000, 6, 32'h800, 0));
    wait_idle("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
